// File: rtl/uart_frame_sched_pkg.sv
// Shared types and default frame constants for the UART frame scheduler.
package uart_frame_sched_pkg;

   typedef enum logic [2:0] {
      IDLE = 3'd0,
      HDR  = 3'd1,
      TYP  = 3'd2,
      PAY  = 3'd3,
      SUM  = 3'd4
   } state_t;

   typedef enum logic {
      KIND_WAVE = 1'b0,
      KIND_FREQ = 1'b1
   } kind_t;

   localparam logic [7:0] HDR_BYTE_DEF  = 8'hA5;
   localparam logic [7:0] TYPE_WAVE_DEF = 8'h01;
   localparam logic [7:0] TYPE_FREQ_DEF = 8'h02;
   localparam int         FREQ_BYTES    = 4;

endpackage

// File: rtl/uart_frame_sched_csum.sv
// frame_csum8: 8-bit modulo-256 running sum with synchronous clear.
module frame_csum8 (
   input  logic       aclk,
   input  logic       rstn,
   input  logic       i_clr,
   input  logic       i_add,
   input  logic [7:0] i_data,
   output logic [7:0] o_sum
);

   logic [7:0] r_sum;

   // NOTE: clocked state uses <= so every register samples pre-edge values.
   always_ff @(posedge aclk or negedge rstn) begin
      if (!rstn)      r_sum <= 8'h00;
      else if (i_clr) r_sum <= 8'h00;
      else if (i_add) r_sum <= r_sum + i_data;
   end

   assign o_sum = r_sum;

endmodule

// File: rtl/uart_frame_sched.sv
// Round-robin framer sharing one UART byte transmitter between the waveform
// FIFO and the frequency result; frames are HDR, TYPE, payload, checksum.
module uart_frame_sched
   import uart_frame_sched_pkg::*;
#(
   parameter int         WAVE_LEN  = 16,
   parameter logic [7:0] HDR_BYTE  = HDR_BYTE_DEF,
   parameter logic [7:0] TYPE_WAVE = TYPE_WAVE_DEF,
   parameter logic [7:0] TYPE_FREQ = TYPE_FREQ_DEF
) (
   input  logic        aclk,
   input  logic        rstn,
   input  logic        cfg_wave_en,
   input  logic        cfg_freq_en,
   input  logic        freq_en,
   input  logic [31:0] freq,
   input  logic        blk_rdy,
   input  logic        wave_valid,
   input  logic [7:0]  wave_data,
   output logic        wave_rd,
   input  logic        tx_ready,
   output logic        tx_en,
   output logic [7:0]  tx_data,
   output logic        busy,
   output logic        freq_ovr
);

   localparam logic [7:0] WAVE_LAST = 8'(WAVE_LEN - 1);
   localparam logic [7:0] FREQ_LAST = 8'(FREQ_BYTES - 1);

   state_t      r_state, w_state_nxt;
   kind_t       r_kind, w_grant_kind;
   logic        w_grant, w_fire, w_snap, w_cap, w_req_f, w_req_w;
   logic        r_guard, r_freq_pend, r_freq_ovr;
   logic [7:0]  r_cnt, w_pay_last, w_sum;
   logic [31:0] r_freq_hold, r_shift;

   assign w_req_f    = r_freq_pend & cfg_freq_en;
   assign w_req_w    = blk_rdy & cfg_wave_en;
   assign w_cap      = freq_en & cfg_freq_en;
   assign w_snap     = w_grant & (w_grant_kind == KIND_FREQ);
   assign w_pay_last = (r_kind == KIND_WAVE) ? WAVE_LAST : FREQ_LAST;

   always_ff @(posedge aclk or negedge rstn) begin
      if (!rstn) r_state <= IDLE;
      else       r_state <= w_state_nxt;
   end

   // NOTE: every always_comb output gets a default first, so no path infers a latch.
   always_comb begin
      w_state_nxt  = r_state;
      w_grant      = 1'b0;
      w_grant_kind = r_kind;
      w_fire       = 1'b0;
      wave_rd      = 1'b0;
      tx_data      = 8'h00;
      case (r_state)
         IDLE: begin
            if (w_req_f | w_req_w) begin
               w_grant = 1'b1;
               // r_kind is the last grant: a tie goes to the other producer
               if (w_req_f & w_req_w)
                  w_grant_kind = (r_kind == KIND_FREQ) ? KIND_WAVE : KIND_FREQ;
               else
                  w_grant_kind = w_req_f ? KIND_FREQ : KIND_WAVE;
               w_state_nxt = HDR;
            end
         end
         HDR: begin
            tx_data = HDR_BYTE;
            w_fire  = tx_ready & ~r_guard;
            if (w_fire) w_state_nxt = TYP;
         end
         TYP: begin
            tx_data = (r_kind == KIND_WAVE) ? TYPE_WAVE : TYPE_FREQ;
            w_fire  = tx_ready & ~r_guard;
            if (w_fire) w_state_nxt = PAY;
         end
         PAY: begin
            if (r_kind == KIND_WAVE) begin
               tx_data = wave_data;
               w_fire  = tx_ready & ~r_guard & wave_valid;
               wave_rd = w_fire;
            end else begin
               tx_data = r_shift[31:24];
               w_fire  = tx_ready & ~r_guard;
            end
            if (w_fire && (r_cnt == w_pay_last)) w_state_nxt = SUM;
         end
         SUM: begin
            tx_data = w_sum;
            w_fire  = tx_ready & ~r_guard;
            if (w_fire) w_state_nxt = IDLE;
         end
         default: w_state_nxt = IDLE;
      endcase
      tx_en = w_fire;
   end

   always_ff @(posedge aclk or negedge rstn) begin
      if (!rstn) begin
         r_guard     <= 1'b0;
         r_kind      <= KIND_WAVE;
         r_cnt       <= 8'h00;
         r_shift     <= 32'h0;
         r_freq_hold <= 32'h0;
         r_freq_pend <= 1'b0;
         r_freq_ovr  <= 1'b0;
      end else begin
         // TX lowers tx_ready one cycle late, so block the cycle after a strobe
         r_guard <= w_fire;
         if (w_grant) begin
            r_kind <= w_grant_kind;
            r_cnt  <= 8'h00;
         end else if (w_fire && (r_state == PAY)) begin
            r_cnt  <= r_cnt + 8'd1;
         end
         if (w_snap)                              r_shift <= r_freq_hold;
         else if (w_fire && (r_state == PAY))     r_shift <= {r_shift[23:0], 8'h00};
         if (w_cap) begin
            r_freq_hold <= freq;
            r_freq_pend <= 1'b1;
            if (r_freq_pend && !w_snap) r_freq_ovr <= 1'b1;
         end else if (w_snap) begin
            r_freq_pend <= 1'b0;
         end
      end
   end

   frame_csum8 u_csum (
      .aclk   (aclk),
      .rstn   (rstn),
      .i_clr  (w_grant),
      .i_add  (w_fire & ((r_state == TYP) | (r_state == PAY))),
      .i_data (tx_data),
      .o_sum  (w_sum)
   );

   assign busy     = (r_state != IDLE);
   assign freq_ovr = r_freq_ovr;

endmodule

// File: tb/tb_uart_frame_sched.sv
// Bench for uart_frame_sched: TX/FIFO models plus a frame-level reference of
// the expected byte stream, with directed and randomized traffic.
module tb_uart_frame_sched;

   localparam int         WLEN  = 4;
   localparam logic [7:0] E_HDR = 8'hA5;
   localparam logic [7:0] E_TW  = 8'h01;
   localparam logic [7:0] E_TF  = 8'h02;

   logic        aclk = 1'b0;
   logic        rstn = 1'b0;
   logic        cfg_wave_en = 1'b1, cfg_freq_en = 1'b1;
   logic        freq_en = 1'b0;
   logic [31:0] freq = 32'h0;
   logic        blk_rdy = 1'b0, wave_valid = 1'b0;
   logic [7:0]  wave_data = 8'h00;
   logic        wave_rd, tx_en, busy, freq_ovr;
   logic        tx_ready = 1'b1;
   logic [7:0]  tx_data;

   uart_frame_sched #(.WAVE_LEN(WLEN)) dut (
      .aclk        (aclk),
      .rstn        (rstn),
      .cfg_wave_en (cfg_wave_en),
      .cfg_freq_en (cfg_freq_en),
      .freq_en     (freq_en),
      .freq        (freq),
      .blk_rdy     (blk_rdy),
      .wave_valid  (wave_valid),
      .wave_data   (wave_data),
      .wave_rd     (wave_rd),
      .tx_ready    (tx_ready),
      .tx_en       (tx_en),
      .tx_data     (tx_data),
      .busy        (busy),
      .freq_ovr    (freq_ovr)
   );

   always #5 aclk = ~aclk;

   int         n_tests = 0, n_fail = 0;
   logic [7:0] rx_q[$], exp_q[$], fifo_q[$];
   logic [7:0] blk[WLEN];
   int         bt = 10, tx_cnt = 0, viol = 0, rd_cnt = 0, en_cnt = 0;
   logic       rdy = 1'b1, prev_en = 1'b0, stall = 1'b0, blk_allow = 1'b1, s_busy = 1'b0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // One clock: drive models at the negedge, sample 1ns later, then advance.
   task automatic step();
      wave_valid = (fifo_q.size() > 0) && !stall;
      wave_data  = (fifo_q.size() > 0) ? fifo_q[0] : 8'h00;
      blk_rdy    = blk_allow && (fifo_q.size() >= WLEN);
      tx_ready   = rdy;
      #1;
      s_busy = busy;
      if (tx_en && (!tx_ready || prev_en)) viol++;
      if (wave_rd && !tx_en) viol++;
      if (tx_en) begin rx_q.push_back(tx_data); en_cnt++; end
      if (wave_rd) begin
         rd_cnt++;
         if (fifo_q.size() > 0) void'(fifo_q.pop_front());
      end
      prev_en = tx_en;
      rdy = (tx_cnt == 0);
      if (tx_en) tx_cnt = bt;
      else if (tx_cnt > 0) tx_cnt--;
      @(negedge aclk);
   endtask

   task automatic do_reset(input string tag);
      rstn = 1'b0; freq_en = 1'b0; tx_ready = 1'b1; wave_valid = 1'b1; blk_rdy = 1'b1;
      #1;
      check({tag, "_tx_en"},   tx_en,    0);
      check({tag, "_wave_rd"}, wave_rd,  0);
      check({tag, "_busy"},    busy,     0);
      check({tag, "_ovr"},     freq_ovr, 0);
      check({tag, "_tx_data"}, tx_data,  8'h00);
      @(negedge aclk);
      @(negedge aclk);
      rstn = 1'b1; prev_en = 1'b0; stall = 1'b0; s_busy = 1'b0;
   endtask

   task automatic strobe_freq(input logic [31:0] v);
      freq = v; freq_en = 1'b1;
      step();
      freq_en = 1'b0; freq = $urandom;
   endtask

   task automatic push_block(input bit rnd);
      for (int i = 0; i < WLEN; i++) begin
         blk[i] = rnd ? 8'($urandom) : 8'(8'h10 * (i + 1));
         fifo_q.push_back(blk[i]);
      end
   endtask

   // Reference frames: header, type, payload, sum of type+payload mod 256.
   function automatic void exp_freq(input logic [31:0] v);
      logic [7:0] s = E_TF;
      exp_q.push_back(E_HDR); exp_q.push_back(E_TF);
      for (int i = 3; i >= 0; i--) begin
         exp_q.push_back(v[8*i +: 8]);
         s += v[8*i +: 8];
      end
      exp_q.push_back(s);
   endfunction

   function automatic void exp_wave();
      logic [7:0] s = E_TW;
      exp_q.push_back(E_HDR); exp_q.push_back(E_TW);
      for (int i = 0; i < WLEN; i++) begin
         exp_q.push_back(blk[i]);
         s += blk[i];
      end
      exp_q.push_back(s);
   endfunction

   task automatic wait_rx(input int n);
      int k = 0;
      while ((rx_q.size() < n || s_busy || tx_cnt != 0) && k < 3000) begin
         step(); k++;
      end
      if (k >= 3000) check("timeout_rx", rx_q.size(), n);
   endtask

   task automatic compare_rx(input string tag);
      check({tag, "_len"}, rx_q.size(), exp_q.size());
      for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++)
         check($sformatf("%s_b%0d", tag, i), rx_q[i], exp_q[i]);
      rx_q.delete(); exp_q.delete();
   endtask

   task automatic tie(input logic [31:0] v);
      blk_allow = 1'b0;
      push_block(1'b1);
      strobe_freq(v);
      blk_allow = 1'b1;
      step();
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int k;
      int en0, rd0;
      logic [31:0] v;

      do_reset("rst0");

      // Freq-only frame, busy/first-byte latency
      strobe_freq(32'h000F4240);
      check("t1_busy_strobe", s_busy, 0);
      step();
      check("t1_busy_grant", s_busy, 0);
      step();
      check("t1_busy_hdr", s_busy, 1);
      check("t1_first_byte", rx_q.size(), 1);
      exp_freq(32'h000F4240);
      wait_rx(7);
      compare_rx("t1");
      check("t1_ovr", freq_ovr, 0);

      // Wave-only frame 10 20 30 40
      rd_cnt = 0;
      push_block(1'b0);
      step();
      exp_wave();
      wait_rx(7);
      compare_rx("t2");
      check("t2_rd_cnt", rd_cnt, WLEN);

      // Two freq strobes during a wave frame: latest wins, ovr sticky
      push_block(1'b1);
      exp_wave();
      repeat (3) step();
      strobe_freq(32'h11111111);
      repeat (5) step();
      strobe_freq(32'h22222222);
      exp_freq(32'h22222222);
      wait_rx(14);
      compare_rx("t4");
      check("t4_ovr", freq_ovr, 1);

      // Ties after reset: freq first, alternating afterwards
      do_reset("rst1");
      v = $urandom; tie(v);
      exp_freq(v); exp_wave();
      wait_rx(14);
      compare_rx("t3a");
      v = $urandom; tie(v);
      exp_freq(v); exp_wave();
      wait_rx(14);
      compare_rx("t3b");
      blk_allow = 1'b0;
      v = $urandom; strobe_freq(v); exp_freq(v);
      wait_rx(7);
      compare_rx("t3c");
      v = $urandom; tie(v);
      exp_wave(); exp_freq(v);
      wait_rx(14);
      compare_rx("t3d");

      // Stall: wave_valid low for 20 cycles mid-payload
      rd_cnt = 0;
      push_block(1'b1);
      exp_wave();
      k = 0;
      while (rd_cnt < 2 && k < 500) begin step(); k++; end
      check("t5_reach_payload", rd_cnt, 2);
      stall = 1'b1;
      en0 = en_cnt; rd0 = rd_cnt;
      repeat (20) step();
      check("t5_gap_tx_en", en_cnt - en0, 0);
      check("t5_gap_wave_rd", rd_cnt - rd0, 0);
      stall = 1'b0;
      wait_rx(3 + WLEN);
      compare_rx("t5");

      // Reset after the third byte of a frame
      strobe_freq(32'hDEADBEEF);
      k = 0;
      while (rx_q.size() < 3 && k < 500) begin step(); k++; end
      check("t6_three_bytes", rx_q.size(), 3);
      do_reset("t6_mid");
      rx_q.delete(); exp_q.delete();
      v = $urandom; strobe_freq(v); exp_freq(v);
      wait_rx(7);
      compare_rx("t6");

      // Randomized frames with random byte times
      for (int it = 0; it < 10; it++) begin
         bt = $urandom_range(1, 12);
         if ($urandom_range(0, 1) == 1) begin
            v = $urandom; strobe_freq(v); exp_freq(v);
         end else begin
            push_block(1'b1); exp_wave(); step();
         end
         wait_rx(exp_q.size());
         compare_rx($sformatf("rnd%0d", it));
      end

      check("protocol_violations", viol, 0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
